// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one read at a time to a
// variable-latency instruction memory and feeds IF/ID one instruction or bubble per cycle.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCout,
    output logic [31:0] instOut,
    output logic        instValid
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic [31:0] skInst, sk_nxt;
    logic [31:0] load_inst;
    logic        load;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == REQ) & ~rst;
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        sk_nxt    = skInst;
        load      = 1'b0;
        load_inst = imem_rdata;
        case (state)
            REQ: begin
                if (branchTaken) begin
                    pc_nxt    = branchAddr;
                    state_nxt = DROP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (branchTaken) begin
                    pc_nxt    = branchAddr;
                    state_nxt = imem_ready ? REQ : DROP;
                end else if (imem_ready && !freeze) begin
                    load      = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = REQ;
                end else if (imem_ready) begin
                    sk_nxt    = imem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    pc_nxt    = branchAddr;
                    state_nxt = REQ;
                end else if (!freeze) begin
                    load      = 1'b1;
                    load_inst = skInst;
                    pc_nxt    = pc_plus4;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                // The stale reply retires the request even if a new redirect lands on the same edge.
                if (branchTaken) pc_nxt = branchAddr;
                if (imem_ready)  state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            pc        <= RESET_PC;
            state     <= REQ;
            // NOTE: skInst is data-only and ignored outside HOLD; it is cleared just to keep it deterministic.
            skInst    <= '0;
            PCout     <= '0;
            instOut   <= NOP_INST;
            instValid <= 1'b0;
        end else begin
            pc     <= pc_nxt;
            state  <= state_nxt;
            skInst <= sk_nxt;
            if (branchTaken) begin
                PCout     <= '0;
                instOut   <= NOP_INST;
                instValid <= 1'b0;
            end else if (!freeze) begin
                if (load) begin
                    PCout     <= pc_plus4;
                    instOut   <= load_inst;
                    instValid <= 1'b1;
                end else begin
                    PCout     <= '0;
                    instOut   <= NOP_INST;
                    instValid <= 1'b0;
                end
            end
        end
    end

endmodule
